pop_count_arbiter: RTL and testbench
====================================

# pop_count_arbiter

Round-robin arbiter that shares one combinational `popCounter` instance between `NUM_REQ` bitmask requesters in the operand matcher. Each accepted bitmask is counted and registered into a single-entry output slot, tagged with the requester ID, under a valid/ready handshake. It replaces per-lane popcount wrappers wherever lanes are not all active every cycle.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `BITMASK_LENGTH`, default 8: bits per mask.
- `BITWIDTH_OUTPUT`, default 4: count width; must be ≥ clog2(`BITMASK_LENGTH`+1).
- `ID_WIDTH`, default 2: clog2(`NUM_REQ`).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester valid.
- `req_bitmask`  in  `NUM_REQ`*`BITMASK_LENGTH`  packed masks; requester i occupies slice [i*L +: L].
- `req_ready`  out  `NUM_REQ`  one-hot (or zero) grant; transfer on `req_valid[i] & req_ready[i]`.
- `out_valid`  out  1  output slot holds a result.
- `out_ready`  in  1  downstream accepts.
- `out_count`  out  `BITWIDTH_OUTPUT`  popcount of the granted mask, zero-extended.
- `out_id`  out  `ID_WIDTH`  index of the requester that produced `out_count`.

## Operation

- Slot state: EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
- `can_accept` = EMPTY | (FULL & `out_ready`).
- Grant: when `can_accept`, choose the first asserted `req_valid[i]` searching from `rr_ptr` upward, modulo `NUM_REQ`. Drive `req_ready[i]`=1 for that i only. Otherwise `req_ready`=0.
- `req_ready` depends on `req_valid`, `rr_ptr`, slot state and `out_ready`. It must not depend on `req_bitmask`.
- On grant of i at a clock edge:
  - slot ← {count(mask_i), i};
  - slot state → FULL;
  - `rr_ptr` ← (i+1) mod `NUM_REQ`.
- No grant but FULL & `out_ready`: slot → EMPTY. `out_count` and `out_id` hold their last values.
- FULL & !`out_ready`: `out_count` and `out_id` stay frozen and no grant is issued.
- Count arithmetic: unsigned sum of mask bits, range 0..`BITMASK_LENGTH`; upper bits of `out_count` are 0.
- `rr_ptr` changes only on a grant. Idle cycles do not advance it.

## Timing

- Reset values, applied asynchronously while `resetn`=0:
  - `out_valid`=0, `out_count`=0, `out_id`=0, `rr_ptr`=0;
  - `req_ready` forced to 0 while in reset.
- Latency: mask accepted at edge t → `out_valid`=1 with its result from t+1.
- Throughput: one result per cycle when `out_ready` is held high. Simultaneous drain and grant in the same cycle yields no bubble.
- Reset asserted mid-transfer drops the slot contents. No partial grant survives reset.
- First grant after reset is evaluated on the first edge with `resetn`=1.
- Requester withdrawing `req_valid` without a transfer is legal and is not recorded.

## Structure

- Shared package `popcount_arb_pkg` holds:
  - default `NUM_REQ`, `BITMASK_LENGTH` and `BITWIDTH_OUTPUT` constants;
  - a `clog2` helper function;
  - a slot typedef {count, id}.
- One sub-module instance: existing `popCounter` (`BITMASK_LENGTH`, `BITWIDTH_OUTPUT`), fed by a mux on the granted mask.
- Round-robin find-first is a local function, not a separate module.
- Target size: about 150–250 lines RTL.

## Test plan

- Reset: hold `resetn`=0 with all `req_valid`=1. Expect `req_ready`=0, `out_valid`=0, `out_count`=0. Release; first grant goes to req0 at the first edge.
- Single requester: req2 mask 8'hB5, `out_ready`=1. Expect `out_count`=5 and `out_id`=2 one cycle after the grant.
- Round-robin fairness: all 4 valid continuously, masks 8'h00/8'hFF/8'h0F/8'h01, `out_ready`=1. Expect `out_id` sequence 0,1,2,3,0,… with counts 0,8,4,1, and no bubbles.
- Backpressure: `out_ready`=0 for 3 cycles while FULL. Expect `req_ready`=0, and `out_count`/`out_id` stable. On `out_ready`=1, drain and a new grant happen in the same cycle.
- Pointer skip: `rr_ptr`=3, only req1 valid. Expect grant to 1, then `rr_ptr`=2.
- Reset mid-stream: assert `resetn` low while FULL. Expect `out_valid`=0 immediately (async). After release, arbitration restarts at req0.

Source files
------------

// File: rtl/pop_count_arbiter_pkg.sv
// popcount_arb_pkg
//   Shared definitions for the pop-count arbiter: default geometry, a
//   constant-evaluable clog2 helper, the output-slot record and the slot
//   state encoding.
package popcount_arb_pkg;

    // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_BITMASK_LENGTH  = 8;
    localparam int DEF_BITWIDTH_OUTPUT = 4;
    localparam int DEF_ID_WIDTH        = clog2(DEF_NUM_REQ);

    // Output slot at the default geometry: {count, id}.
    typedef struct packed {
        logic [DEF_BITWIDTH_OUTPUT-1:0] count;
        logic [DEF_ID_WIDTH-1:0]        id;
    } slot_t;

    // Occupancy of the single-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/pop_count_arbiter_popcounter.sv
// popCounter
//   Purely combinational population count of a bitmask.
//   Ports:
//     bitmask  in   BITMASK_LENGTH   mask to count
//     count    out  BITWIDTH_OUTPUT  number of set bits, zero-extended
module popCounter #(
    parameter int BITMASK_LENGTH  = 8,
    parameter int BITWIDTH_OUTPUT = 4
) (
    input  logic [BITMASK_LENGTH-1:0]  bitmask,
    output logic [BITWIDTH_OUTPUT-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            count = count + BITWIDTH_OUTPUT'(bitmask[i]);
        end
    end

endmodule

// File: rtl/pop_count_arbiter.sv
// pop_count_arbiter
//   Round-robin arbiter sharing one popCounter between NUM_REQ bitmask
//   requesters. The granted mask is counted and registered, tagged with the
//   requester index, into a single-entry output slot.
//
//   Handshake: every channel uses valid/ready. A transfer happens on a rising
//   clock edge where valid & ready are both 1. req_ready is one-hot or zero and
//   never depends on req_bitmask. The producer may drop valid without a
//   transfer; nothing is recorded in that case. out_count/out_id are held
//   stable while out_valid=1 and out_ready=0.
//
//   Ports:
//     clock        in   1                       rising-edge clock
//     resetn       in   1                       async active-low reset
//     req_valid    in   NUM_REQ                 per-requester valid
//     req_bitmask  in   NUM_REQ*BITMASK_LENGTH  requester i at [i*L +: L]
//     req_ready    out  NUM_REQ                 one-hot grant (or zero)
//     out_valid    out  1                       output slot holds a result
//     out_ready    in   1                       downstream accepts
//     out_count    out  BITWIDTH_OUTPUT         popcount of granted mask
//     out_id       out  ID_WIDTH                requester that produced it
//     dbg_state    out  1                       slot state (0 EMPTY, 1 FULL)
//     dbg_rr_ptr   out  ID_WIDTH                round-robin search start
module pop_count_arbiter
    import popcount_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int BITMASK_LENGTH  = DEF_BITMASK_LENGTH,
    parameter int BITWIDTH_OUTPUT = DEF_BITWIDTH_OUTPUT,
    parameter int ID_WIDTH        = clog2(NUM_REQ)
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*BITMASK_LENGTH-1:0]   req_bitmask,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BITWIDTH_OUTPUT-1:0]          out_count,
    output logic [ID_WIDTH-1:0]                 out_id,
    output logic                                dbg_state,
    output logic [ID_WIDTH-1:0]                 dbg_rr_ptr
);

    typedef struct packed {
        logic [BITWIDTH_OUTPUT-1:0] count;
        logic [ID_WIDTH-1:0]        id;
    } slot_w_t;

    // Returns {found, index} of the first set bit of v at or after ptr,
    // wrapping modulo NUM_REQ.
    function automatic logic [ID_WIDTH:0] find_first(
        input logic [NUM_REQ-1:0]  v,
        input logic [ID_WIDTH-1:0] ptr
    );
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        logic [31:0]         p;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            p = 32'(ptr) + 32'(k);
            if (p >= 32'(NUM_REQ)) begin
                p = p - 32'(NUM_REQ);
            end
            if (!found && v[p[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                idx   = p[ID_WIDTH-1:0];
            end
        end
        return {found, idx};
    endfunction

    slot_state_t                state_q, state_d;
    slot_w_t                    slot_q;
    logic [ID_WIDTH-1:0]        rr_ptr_q;

    logic                       can_accept;
    logic                       found;
    logic [ID_WIDTH-1:0]        grant_idx;
    logic                       grant;
    logic [BITMASK_LENGTH-1:0]  grant_mask;
    logic [BITWIDTH_OUTPUT-1:0] grant_count;

    // Grant path. Gating with resetn keeps req_ready low during reset even
    // though the registers are already cleared.
    assign can_accept         = (state_q == SLOT_EMPTY) || out_ready;
    assign {found, grant_idx} = find_first(req_valid, rr_ptr_q);
    assign grant              = resetn && can_accept && found;

    always_comb begin
        req_ready  = '0;
        grant_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                req_ready[i] = grant;
                grant_mask   = req_bitmask[i*BITMASK_LENGTH +: BITMASK_LENGTH];
            end
        end
    end

    popCounter #(
        .BITMASK_LENGTH (BITMASK_LENGTH),
        .BITWIDTH_OUTPUT(BITWIDTH_OUTPUT)
    ) u_pop_counter (
        .bitmask(grant_mask),
        .count  (grant_count)
    );

    // Slot FSM: state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM: next state. A grant always fills the slot, which also covers
    // the drain-and-refill case without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (grant) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !grant) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Slot FSM: outputs.
    always_comb begin
        out_valid = (state_q == SLOT_FULL);
        dbg_state = state_q;
    end

    // Slot payload and pointer only move on a grant; a plain drain leaves
    // out_count/out_id at their last values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_q   <= '0;
            rr_ptr_q <= '0;
        end else if (grant) begin
            slot_q.count <= grant_count;
            slot_q.id    <= grant_idx;
            rr_ptr_q     <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                  : grant_idx + ID_WIDTH'(1);
        end
    end

    assign out_count  = slot_q.count;
    assign out_id     = slot_q.id;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_pop_count_arbiter.sv
module tb_pop_count_arbiter;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int CW = 4;
    localparam int IW = 2;

    logic              clock;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N*L-1:0]    req_bitmask;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_count;
    logic [IW-1:0]     out_id;
    logic              dbg_state;
    logic [IW-1:0]     dbg_rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries are {id, count}.
    logic [IW+CW-1:0] exp_q[$];
    logic [IW+CW-1:0] exp_e;

    pop_count_arbiter #(
        .NUM_REQ        (N),
        .BITMASK_LENGTH (L),
        .BITWIDTH_OUTPUT(CW),
        .ID_WIDTH       (IW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_bitmask(req_bitmask),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_id     (out_id),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_reqs(input logic [N-1:0] v, input logic [N*L-1:0] m, input logic rdy);
        req_valid   = v;
        req_bitmask = m;
        out_ready   = rdy;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Masks: req0=00 (0), req1=FF (8), req2=0F (4), req3=01 (1)
    localparam logic [N*L-1:0] MASKS_A = {8'h01, 8'h0F, 8'hFF, 8'h00};
    // Same but req2=B5 (5)
    localparam logic [N*L-1:0] MASKS_B = {8'h01, 8'hB5, 8'hFF, 8'h00};

    initial begin
        resetn = 1'b0;
        drive_reqs(4'hF, MASKS_A, 1'b1);

        // Reset with every requester valid
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_count", 32'(out_count), 32'h0);
        check("rst_out_id",    32'(out_id),    32'h0);
        check("rst_rr_ptr",    32'(dbg_rr_ptr), 32'h0);

        // Release: first grant is req0
        resetn = 1'b1;
        #1;
        check("first_grant", 32'(req_ready), 32'b0001);

        // Round-robin fairness with all valid, out_ready held high
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({2'd0, 4'd0});
            exp_q.push_back({2'd1, 4'd8});
            exp_q.push_back({2'd2, 4'd4});
            exp_q.push_back({2'd3, 4'd1});
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_no_bubble", 32'(out_valid), 32'h1);
            exp_e = exp_q.pop_front();
            check("rr_slot", 32'({out_id, out_count}), 32'(exp_e));
        end
        check("rr_ptr_wrap", 32'(dbg_rr_ptr), 32'h0);

        // Single requester: req2 mask B5
        drive_reqs(4'b0100, MASKS_B, 1'b1);
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_count", 32'(out_count), 32'd5);
        check("single_id",    32'(out_id),    32'd2);
        check("single_ptr",   32'(dbg_rr_ptr), 32'd3);

        // Drain with no requests: slot empties, payload holds
        drive_reqs(4'b0000, MASKS_B, 1'b1);
        tick();
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_count", 32'(out_count), 32'd5);
        check("drain_id",    32'(out_id),    32'd2);
        check("idle_ptr",    32'(dbg_rr_ptr), 32'd3);

        // Pointer skip: rr_ptr=3, only req1 valid
        drive_reqs(4'b0010, MASKS_B, 1'b1);
        #1;
        check("skip_ready", 32'(req_ready), 32'b0010);
        tick();
        check("skip_id",    32'(out_id),    32'd1);
        check("skip_count", 32'(out_count), 32'd8);
        check("skip_ptr",   32'(dbg_rr_ptr), 32'd2);

        // Backpressure for 3 cycles while FULL
        drive_reqs(4'hF, MASKS_B, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 32'(req_ready), 32'h0);
            tick();
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_slot",  32'({out_id, out_count}), 32'({2'd1, 4'd8}));
        end
        // Release: drain and new grant (req2) in the same cycle
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0100);
        tick();
        check("bp_release_valid", 32'(out_valid), 32'h1);
        check("bp_release_slot",  32'({out_id, out_count}), 32'({2'd2, 4'd5}));

        // Reset mid-stream while FULL, asserted between edges
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_count", 32'(out_count), 32'h0);
        check("async_rst_ready", 32'(req_ready), 32'h0);
        check("async_rst_ptr",   32'(dbg_rr_ptr), 32'h0);
        tick();
        resetn = 1'b1;
        #1;
        check("restart_ready", 32'(req_ready), 32'b0001);
        tick();
        check("restart_slot", 32'({out_valid, out_id, out_count}), 32'({1'b1, 2'd0, 4'd0}));

        // Withdrawn request leaves nothing behind
        drive_reqs(4'b1000, MASKS_B, 1'b1);
        #1;
        drive_reqs(4'b0000, MASKS_B, 1'b1);
        tick();
        check("withdraw_valid", 32'(out_valid), 32'h0);
        check("withdraw_ptr",   32'(dbg_rr_ptr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
